// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared encodings for the multicycle CPU control path: the control-unit
// state enum, the instruction classes produced by the opcode decoder,
// opcode constants, ALU operation codes and the PCSource / ALUSrcB select
// codes. No ports; imported by op_decode and control_unit.
// ---------------------------------------------------------------------------
package cpu_pkg;

   // Control-unit states. The numeric values also appear on the debug port.
   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      EXEC_R  = 4'd2,
      EXEC_I  = 4'd3,
      ALU_WB  = 4'd4,
      MEM_RD  = 4'd5,
      LOAD_WB = 4'd6,
      MEM_WR  = 4'd7,
      BRANCH  = 4'd8,
      JUMP    = 4'd9,
      HALT    = 4'd10
   } state_t;

   // Instruction classes resolved from the opcode.
   typedef enum logic [2:0] {
      CLS_R       = 3'd0,
      CLS_I       = 3'd1,
      CLS_LW      = 3'd2,
      CLS_SW      = 3'd3,
      CLS_BEQ     = 3'd4,
      CLS_J       = 3'd5,
      CLS_HALT    = 3'd6,
      CLS_ILLEGAL = 3'd7
   } iclass_t;

   // Single-opcode instructions. R-type occupies 0x00-0x0F, I-type 0x10-0x1F.
   localparam logic [5:0] OP_LW   = 6'h20;
   localparam logic [5:0] OP_SW   = 6'h21;
   localparam logic [5:0] OP_BEQ  = 6'h22;
   localparam logic [5:0] OP_J    = 6'h23;
   localparam logic [5:0] OP_HALT = 6'h3F;

   // ALU operation codes.
   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_AND = 4'h2;
   localparam logic [3:0] ALU_OR  = 4'h3;
   localparam logic [3:0] ALU_XOR = 4'h4;

   // PCSource selects.
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // ALUSrcB selects.
   localparam logic [1:0] SRCB_REGB = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_SEXT = 2'b10;
   localparam logic [1:0] SRCB_ZEXT = 2'b11;

   // Logical immediates (AND/OR/XOR) take a zero-extended operand; the
   // arithmetic ones take a sign-extended operand.
   function automatic logic is_logic_alu(input logic [3:0] alu_code);
      return (alu_code == ALU_AND) || (alu_code == ALU_OR) || (alu_code == ALU_XOR);
   endfunction

endpackage

// File: rtl/op_decode.sv
// ---------------------------------------------------------------------------
// op_decode
// Purely combinational opcode decoder.
//   op        in  6  instruction opcode (IReg_out[31:26])
//   iclass    out 3  instruction class (cpu_pkg::iclass_t)
//   alu_srcb  out 2  ALUSrcB select to use for an I-type execute
// ---------------------------------------------------------------------------
module op_decode
   import cpu_pkg::*;
(
   input  logic [5:0] op,
   output iclass_t    iclass,
   output logic [1:0] alu_srcb
);

   always_comb begin
      iclass   = CLS_ILLEGAL;
      alu_srcb = SRCB_SEXT;

      if (op[5:4] == 2'b00) begin
         iclass = CLS_R;
      end else if (op[5:4] == 2'b01) begin
         iclass = CLS_I;
      end else begin
         case (op)
            OP_LW:   iclass = CLS_LW;
            OP_SW:   iclass = CLS_SW;
            OP_BEQ:  iclass = CLS_BEQ;
            OP_J:    iclass = CLS_J;
            OP_HALT: iclass = CLS_HALT;
            default: iclass = CLS_ILLEGAL;
         endcase
      end

      if (is_logic_alu(op[3:0])) begin
         alu_srcb = SRCB_ZEXT;
      end
   end

endmodule

// File: rtl/control_unit.sv
// ---------------------------------------------------------------------------
// control_unit
// Multicycle Moore control FSM for the CPU datapath. Each instruction walks
// FETCH -> DECODE -> (execute / memory / write-back) one state per clock.
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous active-low reset
//   IReg_out    in  32  instruction register, opcode in [31:26]
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   ALUSrcA, RegWrite, RegDst   out 1 each  datapath controls
//   PCSource    out  2  PC source select
//   ALUSrcB     out  2  ALU operand B select
//   ALUOp       out  4  ALU operation
//   halted      out  1  high while in HALT
//   illegal_op  out  1  sticky flag, set when an undefined opcode is decoded
//   state       out  4  current state encoding (debug)
// ---------------------------------------------------------------------------
module control_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IReg_out,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        MemtoReg,
   output logic        ALUSrcA,
   output logic        RegWrite,
   output logic        RegDst,
   output logic [1:0]  PCSource,
   output logic [1:0]  ALUSrcB,
   output logic [3:0]  ALUOp,
   output logic        halted,
   output logic        illegal_op,
   output logic [3:0]  state
);

   state_t     state_reg;
   state_t     state_next;
   logic       illegal_reg;
   logic       illegal_next;
   iclass_t    iclass;
   logic [1:0] imm_srcb;
   logic [5:0] opcode;

   // Only the opcode drives control; register and immediate fields are
   // consumed by the datapath.
   logic unused_fields;
   assign unused_fields = ^IReg_out[25:0];

   assign opcode = IReg_out[31:26];

   op_decode u_op_decode (
      .op       (opcode),
      .iclass   (iclass),
      .alu_srcb (imm_srcb)
   );

   // State and sticky flag registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= FETCH;
         illegal_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         illegal_reg <= illegal_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next   = FETCH;
      illegal_next = illegal_reg;
      case (state_reg)
         FETCH:   state_next = DECODE;
         DECODE: begin
            case (iclass)
               CLS_R:    state_next = EXEC_R;
               CLS_I:    state_next = EXEC_I;
               CLS_LW:   state_next = MEM_RD;
               CLS_SW:   state_next = MEM_WR;
               CLS_BEQ:  state_next = BRANCH;
               CLS_J:    state_next = JUMP;
               CLS_HALT: state_next = HALT;
               default: begin
                  state_next   = FETCH;
                  illegal_next = 1'b1;
               end
            endcase
         end
         EXEC_R:  state_next = ALU_WB;
         EXEC_I:  state_next = ALU_WB;
         ALU_WB:  state_next = FETCH;
         MEM_RD:  state_next = LOAD_WB;
         LOAD_WB: state_next = FETCH;
         MEM_WR:  state_next = FETCH;
         BRANCH:  state_next = FETCH;
         JUMP:    state_next = FETCH;
         HALT:    state_next = HALT;
         default: state_next = FETCH;   // unused encodings recover
      endcase
   end

   // Moore output decode.
   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      PCSource    = PCSRC_ALU;
      ALUSrcB     = SRCB_REGB;
      ALUOp       = ALU_ADD;
      halted      = 1'b0;

      case (state_reg)
         FETCH: begin
            IRWrite = 1'b1;
            ALUSrcB = SRCB_ONE;
            PCWrite = 1'b1;
         end
         DECODE: begin
            // ALUOut captures PC+1+sext(imm) as a speculative branch target.
            ALUSrcB = SRCB_SEXT;
         end
         EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = opcode[3:0];
         end
         EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = imm_srcb;
            ALUOp   = opcode[3:0];
         end
         ALU_WB: begin
            RegWrite = 1'b1;
            RegDst   = (iclass == CLS_R);
         end
         MEM_RD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         LOAD_WB: begin
            RegWrite = 1'b1;
            MemtoReg = 1'b1;
         end
         MEM_WR: begin
            MemWrite = 1'b1;
            IorD     = 1'b1;
         end
         BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = ALU_SUB;
            PCSource    = PCSRC_ALUOUT;
            PCWriteCond = 1'b1;
         end
         JUMP: begin
            PCSource = PCSRC_JUMP;
            PCWrite  = 1'b1;
         end
         HALT: begin
            halted = 1'b1;
         end
         default: ;
      endcase

      // Reset kills every control line without waiting for a clock edge.
      if (!reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         MemtoReg    = 1'b0;
         ALUSrcA     = 1'b0;
         RegWrite    = 1'b0;
         RegDst      = 1'b0;
         PCSource    = PCSRC_ALU;
         ALUSrcB     = SRCB_REGB;
         ALUOp       = ALU_ADD;
         halted      = 1'b0;
      end
   end

   assign illegal_op = illegal_reg;
   assign state      = state_reg;

endmodule

// File: tb/tb_control_unit.sv
// ---------------------------------------------------------------------------
// tb_control_unit
// Directed bench for control_unit. A behavioural model turns each issued
// opcode into the per-cycle sequence of control vectors it must produce; a
// single compare process checks the DUT against that on every falling edge.
// Literal checks on captured cycles pin the model to hand-worked values.
// ---------------------------------------------------------------------------
module tb_control_unit;

   typedef struct packed {
      logic       pcw;
      logic       pcwc;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       irw;
      logic       m2r;
      logic       srca;
      logic       rw;
      logic       rdst;
      logic [1:0] pcsrc;
      logic [1:0] srcb;
      logic [3:0] aluop;
      logic       halted;
      logic       ill;
      logic [3:0] st;
   } ctrl_t;

   logic        clk;
   logic        reset;
   logic [31:0] IReg_out;
   logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic        MemtoReg, ALUSrcA, RegWrite, RegDst;
   logic [1:0]  PCSource, ALUSrcB;
   logic [3:0]  ALUOp;
   logic        halted, illegal_op;
   logic [3:0]  state;

   ctrl_t dut_vec;
   ctrl_t exp_vec;
   ctrl_t cap [0:3];
   logic  check_en;
   logic  m_ill;
   int    n_tests;
   int    n_fail;

   control_unit dut (
      .clk         (clk),
      .reset       (reset),
      .IReg_out    (IReg_out),
      .PCWrite     (PCWrite),
      .PCWriteCond (PCWriteCond),
      .IorD        (IorD),
      .MemRead     (MemRead),
      .MemWrite    (MemWrite),
      .IRWrite     (IRWrite),
      .MemtoReg    (MemtoReg),
      .ALUSrcA     (ALUSrcA),
      .RegWrite    (RegWrite),
      .RegDst      (RegDst),
      .PCSource    (PCSource),
      .ALUSrcB     (ALUSrcB),
      .ALUOp       (ALUOp),
      .halted      (halted),
      .illegal_op  (illegal_op),
      .state       (state)
   );

   assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                     MemtoReg, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB,
                     ALUOp, halted, illegal_op, state};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Instruction kinds: 0 R, 1 I, 2 LW, 3 SW, 4 BEQ, 5 J, 6 HALT, 7 illegal.
   function automatic int kind(input logic [5:0] op);
      if (op < 6'h10) return 0;
      if (op < 6'h20) return 1;
      case (op)
         6'h20:   return 2;
         6'h21:   return 3;
         6'h22:   return 4;
         6'h23:   return 5;
         6'h3F:   return 6;
         default: return 7;
      endcase
   endfunction

   function automatic int cycles(input logic [5:0] op);
      case (kind(op))
         0, 1, 2: return 4;
         3, 4, 5: return 3;
         6:       return 22;   // fetch, decode, then 20 observed HALT cycles
         default: return 2;
      endcase
   endfunction

   // Expected control vector for cycle s (0 = fetch) of instruction op.
   function automatic ctrl_t model(input logic [5:0] op, input int s, input logic ill);
      ctrl_t      e;
      logic [3:0] lo;
      lo    = op[3:0];
      e     = '0;
      e.ill = ill;
      if (s == 0) begin
         e.irw = 1'b1; e.pcw = 1'b1; e.srcb = 2'b01; e.st = 4'd0;
      end else if (s == 1) begin
         e.srcb = 2'b10; e.st = 4'd1;
      end else begin
         case (kind(op))
            0: if (s == 2) begin e.srca = 1'b1; e.aluop = lo; e.st = 4'd2; end
               else begin e.rw = 1'b1; e.rdst = 1'b1; e.st = 4'd4; end
            1: if (s == 2) begin
                  e.srca  = 1'b1; e.aluop = lo; e.st = 4'd3;
                  e.srcb  = (lo >= 4'd2 && lo <= 4'd4) ? 2'b11 : 2'b10;
               end else begin e.rw = 1'b1; e.st = 4'd4; end
            2: if (s == 2) begin e.mrd = 1'b1; e.iord = 1'b1; e.st = 4'd5; end
               else begin e.rw = 1'b1; e.m2r = 1'b1; e.st = 4'd6; end
            3: begin e.mwr = 1'b1; e.iord = 1'b1; e.st = 4'd7; end
            4: begin e.srca = 1'b1; e.aluop = 4'h1; e.pcsrc = 2'b01; e.pcwc = 1'b1; e.st = 4'd8; end
            5: begin e.pcsrc = 2'b10; e.pcw = 1'b1; e.st = 4'd9; end
            6: begin e.halted = 1'b1; e.st = 4'd10; end
            default: ;
         endcase
      end
      return e;
   endfunction

   // Single compare process: whole control vector, every cycle.
   always @(negedge clk) begin
      if (check_en) check("ctrl_vec", 32'(dut_vec), 32'(exp_vec));
   end

   // Issue one instruction; walks it through its full cycle count.
   task automatic issue(input logic [5:0] op);
      int n;
      IReg_out = {op, 26'($urandom)};
      n = cycles(op);
      for (int s = 0; s < n; s++) begin
         exp_vec = model(op, s, m_ill);
         @(negedge clk); #1;
         if (s < 4) cap[s] = dut_vec;
         @(posedge clk); #1;
      end
      if (kind(op) == 7) m_ill = 1'b1;
      $display("[TB] instr op=%02h cycles=%0d illegal_op=%0b", op, n, m_ill);
   endtask

   task automatic assert_reset();
      reset   = 1'b0;
      m_ill   = 1'b0;
      exp_vec = '0;
   endtask

   task automatic release_reset();
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      check_en = 1'b0;
      IReg_out = 32'h0;
      assert_reset();
      repeat (2) @(posedge clk);
      #1 check_en = 1'b1;
      @(negedge clk); #1;
      check("reset_state", 32'(state), 32'd0);
      release_reset();

      // R-type ADD
      issue(6'h00);
      check("add_fetch_pcwrite", 32'(cap[0].pcw), 32'd1);
      check("add_fetch_irwrite", 32'(cap[0].irw), 32'd1);
      check("add_fetch_srcb", 32'(cap[0].srcb), 32'd1);
      check("add_wb_regwrite", 32'(cap[3].rw), 32'd1);
      check("add_wb_regdst", 32'(cap[3].rdst), 32'd1);
      check("add_wb_memtoreg", 32'(cap[3].m2r), 32'd0);
      check("add_cycle5_fetch", 32'(state), 32'd0);

      // I-type
      issue(6'h13);
      check("ori_srcb", 32'(cap[2].srcb), 32'd3);
      check("ori_aluop", 32'(cap[2].aluop), 32'd3);
      issue(6'h10);
      check("addi_srcb", 32'(cap[2].srcb), 32'd2);
      check("addi_aluop", 32'(cap[2].aluop), 32'd0);
      issue(6'h11);

      // Load / store
      issue(6'h20);
      check("lw_memread", 32'(cap[2].mrd), 32'd1);
      check("lw_iord", 32'(cap[2].iord), 32'd1);
      check("lw_wb_memtoreg", 32'(cap[3].m2r), 32'd1);
      check("lw_wb_regwrite", 32'(cap[3].rw), 32'd1);
      issue(6'h21);
      check("sw_memwrite", 32'(cap[2].mwr), 32'd1);
      check("sw_memwrite_decode", 32'(cap[1].mwr), 32'd0);
      check("sw_memwrite_after", 32'(MemWrite), 32'd0);

      // Branch / jump
      issue(6'h22);
      check("beq_pcwcond", 32'(cap[2].pcwc), 32'd1);
      check("beq_pcsource", 32'(cap[2].pcsrc), 32'd1);
      check("beq_aluop", 32'(cap[2].aluop), 32'd1);
      check("beq_pcwrite", 32'(cap[2].pcw), 32'd0);
      issue(6'h23);
      check("j_pcwrite", 32'(cap[2].pcw), 32'd1);
      check("j_pcsource", 32'(cap[2].pcsrc), 32'd2);

      // Illegal opcode, then the flag must persist through an ADD
      issue(6'h30);
      check("ill_set", 32'(illegal_op), 32'd1);
      issue(6'h00);
      check("ill_sticky", 32'(illegal_op), 32'd1);
      issue(6'h0C);
      issue(6'h14);

      // Reset asserted in the middle of MEM_WR
      IReg_out = {6'h21, 26'h0};
      for (int s = 0; s < 3; s++) begin
         exp_vec = model(6'h21, s, m_ill);
         if (s < 2) begin @(posedge clk); #1; end
      end
      @(negedge clk); #1;
      check("midrst_memwrite_before", 32'(MemWrite), 32'd1);
      assert_reset();
      #1;
      check("midrst_memwrite", 32'(MemWrite), 32'd0);
      check("midrst_state", 32'(state), 32'd0);
      check("midrst_illegal", 32'(illegal_op), 32'd0);
      $display("[TB] instr op=21 interrupted by reset in MEM_WR");
      release_reset();
      issue(6'h00);
      check("post_rst_fetch_pcwrite", 32'(cap[0].pcw), 32'd1);

      // HALT: held for 20 cycles with every control low
      issue(6'h3F);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_pcwrite", 32'(PCWrite), 32'd0);
      assert_reset();
      #1;
      check("halt_rst_halted", 32'(halted), 32'd0);
      release_reset();
      issue(6'h00);

      check_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
